// File: rtl/io_pkg.sv
// Shared I/O constants: switch width, debounce defaults and the I/O-region map seen by the LSU.
package io_pkg;

  localparam int unsigned SW_WIDTH          = 18;
  localparam int unsigned SW_TICK_DIV       = 50000;  // 1 ms sample period at 50 MHz
  localparam int unsigned SW_STABLE_SAMPLES = 4;

  localparam logic [31:0] IO_BASE      = 32'h1000_0000;
  localparam logic [31:0] IO_LEDR_BASE = 32'h1000_0000;
  localparam logic [31:0] IO_LEDG_BASE = 32'h1000_1000;
  localparam logic [31:0] IO_HEX_BASE  = 32'h1000_2000;
  localparam logic [31:0] IO_LCD_BASE  = 32'h1000_4000;
  localparam logic [31:0] IO_SW_BASE   = 32'h1001_0000;

  // Debounced edge decision for one switch bit on a given cycle.
  typedef enum logic [1:0] {
    EdgeNone,
    EdgeRise,
    EdgeFall
  } edge_e;

  // Prescaler width; never less than one bit so TICK_DIV=1 still builds.
  function automatic int unsigned cnt_width(int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/io_sw_debounce_if.sv
// Switch-conditioning bundle: raw switch levels in, debounced levels, edge pulses and tick out.
interface io_sw_debounce_if
  import io_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH
) ();

  logic [WIDTH-1:0] i_sw;
  logic [WIDTH-1:0] o_sw;
  logic [WIDTH-1:0] o_sw_rise;
  logic [WIDTH-1:0] o_sw_fall;
  logic             o_tick;

  modport master (
    output i_sw,
    input  o_sw,
    input  o_sw_rise,
    input  o_sw_fall,
    input  o_tick
  );

  modport slave (
    input  i_sw,
    output o_sw,
    output o_sw_rise,
    output o_sw_fall,
    output o_tick
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; synchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_d;
      sync2_q <= sync1_q;
    end
  end

  assign o_q = sync2_q;

endmodule

// File: rtl/io_sw_debounce.sv
// Switch debouncer: 2FF sync, shared sample-tick prescaler, per-bit sample history,
// registered debounced level plus one-cycle rise/fall pulses.
module io_sw_debounce
  import io_pkg::*;
#(
  parameter int unsigned WIDTH          = SW_WIDTH,
  parameter int unsigned TICK_DIV       = SW_TICK_DIV,
  parameter int unsigned STABLE_SAMPLES = SW_STABLE_SAMPLES
) (
  input  logic            i_clk,
  input  logic            i_reset,
  io_sw_debounce_if.slave sw_if
);

  localparam int unsigned CntW = cnt_width(TICK_DIV);
  localparam int unsigned S    = STABLE_SAMPLES;

  logic [WIDTH-1:0] sync2;

  sync_2ff #(
    .WIDTH(WIDTH)
  ) u_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (sw_if.i_sw),
    .o_q    (sync2)
  );

  // Prescaler
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_now;
  logic            tick_q;

  assign tick_now = (cnt_q == CntW'(TICK_DIV - 1));
  assign cnt_d    = tick_now ? '0 : cnt_q + CntW'(1);

  // History and debounced state
  logic [WIDTH-1:0][S-1:0] hist_q, hist_d;
  logic [WIDTH-1:0]        sw_q, sw_d;
  logic [WIDTH-1:0]        rise_q, rise_d;
  logic [WIDTH-1:0]        fall_q, fall_d;
  edge_e                   edge_kind [WIDTH];

  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      hist_d[b]    = hist_q[b];
      edge_kind[b] = EdgeNone;
      if (tick_now) begin
        hist_d[b] = {hist_q[b][S-2:0], sync2[b]};
        // Decision uses the freshly shifted history so the change lands on the sampling edge.
        if ((&hist_d[b]) && !sw_q[b]) begin
          edge_kind[b] = EdgeRise;
        end else if (!(|hist_d[b]) && sw_q[b]) begin
          edge_kind[b] = EdgeFall;
        end
      end
    end
  end

  always_comb begin
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    for (int b = 0; b < WIDTH; b++) begin
      unique case (edge_kind[b])
        EdgeRise: begin
          sw_d[b]   = 1'b1;
          rise_d[b] = 1'b1;
        end
        EdgeFall: begin
          sw_d[b]   = 1'b0;
          fall_d[b] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      hist_q <= '0;
      sw_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_now;
      hist_q <= hist_d;
      sw_q   <= sw_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sw_if.o_sw      = sw_q;
  assign sw_if.o_sw_rise = rise_q;
  assign sw_if.o_sw_fall = fall_q;
  assign sw_if.o_tick    = tick_q;

  rise_fall_exclusive_a : assert property (@(posedge i_clk) disable iff (!i_reset)
    ((rise_q & fall_q) == '0));

endmodule

// File: tb/tb_io_sw_debounce.sv
// Bench: three debouncer configurations checked every cycle against a run-length model.
module tb_io_sw_debounce;
  import io_pkg::*;

  localparam int unsigned W  = SW_WIDTH;
  localparam int          NI = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw    = '0;
  int           checks   = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  io_sw_debounce_if #(.WIDTH(W)) if0 ();
  io_sw_debounce_if #(.WIDTH(W)) if1 ();
  io_sw_debounce_if #(.WIDTH(W)) if2 ();

  assign if0.i_sw = sw;
  assign if1.i_sw = sw;
  assign if2.i_sw = sw;

  io_sw_debounce #(.WIDTH(W), .TICK_DIV(1), .STABLE_SAMPLES(3)) u_dut0 (
    .i_clk(clk), .i_reset(rst_n), .sw_if(if0)
  );
  io_sw_debounce #(.WIDTH(W), .TICK_DIV(4), .STABLE_SAMPLES(3)) u_dut1 (
    .i_clk(clk), .i_reset(rst_n), .sw_if(if1)
  );
  io_sw_debounce #(.WIDTH(W), .TICK_DIV(3), .STABLE_SAMPLES(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst_n), .sw_if(if2)
  );

  function automatic int cfg_td(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_ss(input int k);
    return (k == 2) ? 2 : 3;
  endfunction

  task automatic read_dut(input int k, output logic [W-1:0] o, output logic [W-1:0] r,
                          output logic [W-1:0] f, output logic t);
    case (k)
      0: begin o = if0.o_sw; r = if0.o_sw_rise; f = if0.o_sw_fall; t = if0.o_tick; end
      1: begin o = if1.o_sw; r = if1.o_sw_rise; f = if1.o_sw_fall; t = if1.o_tick; end
      default: begin o = if2.o_sw; r = if2.o_sw_rise; f = if2.o_sw_fall; t = if2.o_tick; end
    endcase
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a debounced bit follows its sample stream once the same value has been
  // seen on the last S ticks in a row; samples are the input delayed two clocks.
  logic [W-1:0] m_d1   [NI];
  logic [W-1:0] m_d2   [NI];
  logic [W-1:0] m_last [NI];
  logic [W-1:0] m_out  [NI];
  logic [W-1:0] m_rise [NI];
  logic [W-1:0] m_fall [NI];
  logic         m_tick [NI];
  int           m_run  [NI][W];
  int           m_edges[NI];

  task automatic model_edge(input int k, input logic rn, input logic [W-1:0] in);
    bit tick;
    if (!rn) begin
      m_d1[k] = '0; m_d2[k] = '0; m_last[k] = '0; m_out[k] = '0;
      m_rise[k] = '0; m_fall[k] = '0; m_tick[k] = 1'b0; m_edges[k] = 0;
      for (int b = 0; b < W; b++) m_run[k][b] = cfg_ss(k);
    end else begin
      tick = ((m_edges[k] % cfg_td(k)) == cfg_td(k) - 1);
      m_edges[k]++;
      m_rise[k] = '0;
      m_fall[k] = '0;
      if (tick) begin
        for (int b = 0; b < W; b++) begin
          if (m_d2[k][b] == m_last[k][b]) begin
            if (m_run[k][b] < 1000) m_run[k][b]++;
          end else begin
            m_last[k][b] = m_d2[k][b];
            m_run[k][b]  = 1;
          end
          if (m_run[k][b] >= cfg_ss(k) && m_last[k][b] != m_out[k][b]) begin
            m_out[k][b] = m_last[k][b];
            if (m_last[k][b]) m_rise[k][b] = 1'b1;
            else              m_fall[k][b] = 1'b1;
          end
        end
      end
      m_d2[k]   = m_d1[k];
      m_d1[k]   = in;
      m_tick[k] = tick;
    end
  endtask

  // Compare process: advance model on each rising edge, check DUTs on the falling edge.
  initial begin
    logic [W-1:0] o, r, f;
    logic         t;
    forever begin
      @(posedge clk);
      for (int k = 0; k < NI; k++) model_edge(k, rst_n, sw);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        read_dut(k, o, r, f, t);
        check_vec($sformatf("dut%0d o_sw", k), o, m_out[k]);
        check_vec($sformatf("dut%0d o_sw_rise", k), r, m_rise[k]);
        check_vec($sformatf("dut%0d o_sw_fall", k), f, m_fall[k]);
        check_vec($sformatf("dut%0d o_tick", k), W'(t), W'(m_tick[k]));
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] o, r, f, seen;
    logic         t;
    logic [W-1:0] mask;

    // Reset held with all switches high
    rst_n = 1'b0;
    sw    = '1;
    settle(3);
    read_dut(0, o, r, f, t);
    check_vec("reset o_sw", o, '0);
    check_vec("reset pulses", r | f, '0);
    check_vec("reset o_tick", W'(t), '0);
    rst_n = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      read_dut(0, o, r, f, t);
      if (n == 4) check_vec("post-reset o_sw before debounce", o, '0);
      if (n == 5) begin
        check_vec("post-reset o_sw debounced", o, '1);
        check_vec("post-reset rise", r, '1);
      end
      if (n == 6) check_vec("post-reset rise one cycle", r, '0);
      read_dut(1, o, r, f, t);
      if (n == 3 || n == 4 || n == 8 || n == 12)
        check_vec($sformatf("tick div4 cycle %0d", n), W'(t), W'(n % 4 == 0));
    end
    sw = '0;
    settle(40);

    // Clean rise on bit 0
    sw = 18'h00001;
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      read_dut(0, o, r, f, t);
      if (e == 3) check_vec("clean rise edge3 o_sw", o, '0);
      if (e == 4) begin
        check_vec("clean rise edge4 o_sw", o, 18'h00001);
        check_vec("clean rise edge4 rise", r, 18'h00001);
        check_vec("clean rise edge4 fall", f, '0);
      end
      if (e == 5) check_vec("clean rise edge5 rise", r, '0);
    end
    sw = '0;
    settle(40);

    // Two-cycle glitch on bit 5
    seen = '0;
    sw   = 18'h00020;
    @(negedge clk);
    read_dut(0, o, r, f, t);
    seen |= o | r | f;
    @(negedge clk);
    sw = '0;
    for (int i = 0; i < 10; i++) begin
      read_dut(0, o, r, f, t);
      seen |= o | r | f;
      @(negedge clk);
    end
    check_vec("glitch rejected", seen, '0);

    // Multi-bit rise then simultaneous fall
    sw = 18'h00011;
    settle(40);
    sw = '0;
    for (int e = 0; e <= 4; e++) begin
      @(negedge clk);
      read_dut(0, o, r, f, t);
      if (e == 3) check_vec("multi fall edge3 o_sw", o, 18'h00011);
      if (e == 4) begin
        check_vec("multi fall edge4 fall", f, 18'h00011);
        check_vec("multi fall edge4 o_sw", o, '0);
      end
    end
    settle(40);

    // Reset after two stable samples of bit 2
    sw = 18'h00004;
    settle(4);
    rst_n = 1'b0;
    @(negedge clk);
    read_dut(0, o, r, f, t);
    check_vec("mid reset o_sw", o, '0);
    check_vec("mid reset pulses", r | f, '0);
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      read_dut(0, o, r, f, t);
      if (n == 4) check_vec("mid reset edge4 o_sw", o, '0);
      if (n == 5) begin
        check_vec("mid reset edge5 o_sw", o, 18'h00004);
        check_vec("mid reset edge5 rise", r, 18'h00004);
      end
    end
    sw = '0;
    settle(40);

    // Random bouncing with occasional resets
    for (int i = 0; i < 3000; i++) begin
      mask = '0;
      for (int b = 0; b < W; b++) mask[b] = ($urandom_range(0, 23) == 0);
      sw    = sw ^ mask;
      rst_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    settle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_sw_debounce.md
Name: io_sw_debounce

Overview:
- Input-conditioning stage directly upstream of the single-cycle core's switch input port (`i_io_sw`).
- Takes raw asynchronous board switches (SW[17:0]), synchronises each bit into `i_clk`, and debounces it with a shared sample-tick prescaler and per-bit sample history.
- Drives a clean, stable switch vector plus one-cycle rise/fall pulses, so software polling the switch I/O region never sees metastable or bouncing values.

Parameters:
- WIDTH, 18, number of switch bits conditioned.
- TICK_DIV, 50000, clock cycles per sample tick (1 ms at 50 MHz); legal range ≥ 1.
- STABLE_SAMPLES, 4, consecutive equal samples required before the output changes; legal range ≥ 2.

Ports:
- i_clk  input  1  system clock (CLOCK_50 domain).
- i_reset  input  1  synchronous, active-low reset (0 = reset).
- i_sw  input  WIDTH  raw asynchronous switch levels.
- o_sw  output  WIDTH  debounced level; feeds the core's switch input, zero-extended to 32 bits.
- o_sw_rise  output  WIDTH  one-cycle pulse per bit on a debounced 0→1 change.
- o_sw_fall  output  WIDTH  one-cycle pulse per bit on a debounced 1→0 change.
- o_tick  output  1  one-cycle sample strobe (debug/visibility).

Behaviour:
- Reset:
  - Sampled only on the rising edge of `i_clk` when i_reset=0.
  - Clears: both synchroniser stages, prescaler count, all history bits, o_sw, o_sw_rise, o_sw_fall, o_tick.
  - All outputs read 0 in the cycle after the reset edge.
  - Reset asserted mid-debounce discards partial history; no pulse is emitted.
- Synchroniser:
  - Two flops per bit: sync1 <= i_sw; sync2 <= sync1.
  - Only sync2 is used downstream.
- Prescaler:
  - Counter of width $clog2(TICK_DIV) (minimum 1 bit) counts 0..TICK_DIV-1 and wraps to 0.
  - o_tick is registered: it is 1 for exactly the cycle after the edge on which the count wrapped.
  - The first o_tick appears TICK_DIV edges after reset release.
  - TICK_DIV=1 makes o_tick permanently 1 after reset release.
  - Sampling uses an internal tick_now = (count==TICK_DIV-1), not the registered o_tick.
- History, per bit:
  - STABLE_SAMPLES-bit shift register hist.
  - On a tick_now edge: hist <= {hist[S-2:0], sync2}.
  - Let nh be the shifted value. If nh is all ones and o_sw=0, then on the same edge: o_sw<=1 and o_sw_rise<=1.
  - If nh is all zeros and o_sw=1, then on the same edge: o_sw<=0 and o_sw_fall<=1.
  - Otherwise o_sw holds.
- Edge pulses:
  - Default to 0 every cycle; each pulse lasts exactly one cycle.
  - Rise and fall are never both 1 on the same bit.
- Bit independence: bits are fully independent; simultaneous changes on several bits produce simultaneous pulses.
- Latency:
  - A clean input change reaches o_sw after 2 sync cycles plus STABLE_SAMPLES ticks.
  - Worst case: 2 + STABLE_SAMPLES*TICK_DIV cycles.
  - With TICK_DIV=1: i_sw high before edge 0 gives o_sw=1 after edge 4 for S=3.
- Glitch rejection: any toggle shorter than STABLE_SAMPLES ticks (as seen at sync2) leaves o_sw unchanged.
- No combinational path from i_sw to any output.

Decomposition:
- Shared package io_pkg:
  - SW_WIDTH=18.
  - Default TICK_DIV and STABLE_SAMPLES constants.
  - I/O-region base-address constants already used by the LSU.
- One sub-module, sync_2ff (parameter WIDTH, two-flop synchroniser, same clock/reset convention). It is reused later for other asynchronous board inputs.
- The prescaler and history stay inline.

Test Plan:
- Reset: hold i_reset=0 with i_sw=18'h3FFFF for 3 cycles -> o_sw=0, pulses=0, o_tick=0; after release, o_sw=0 until debounce completes.
- Clean rise (TICK_DIV=1, S=3): i_sw[0] 0→1 before edge 0 -> o_sw[0]=1 after edge 4; o_sw_rise[0]=1 for exactly that cycle only; o_sw_fall=0.
- Glitch (TICK_DIV=1, S=3): i_sw[5]=1 for 2 cycles then 0 -> o_sw[5] stays 0; no rise or fall pulse.
- Tick period (TICK_DIV=4): after reset release, o_tick=1 on cycles 4, 8, 12; a bit change stable for 3 ticks updates o_sw within 2+12 cycles.
- Multi-bit and fall: set i_sw=18'h00011 until stable, then drop to 0 -> o_sw_fall[0] and o_sw_fall[4] pulse in the same cycle, and o_sw returns to 0.
- Reset mid-operation (TICK_DIV=1, S=3): after 2 stable samples of i_sw[2]=1, assert reset for 1 cycle -> no pulse; o_sw[2] rises only 5 cycles after reset release.
